// File: rtl/adc_axi_pkg.sv
// ---------------------------------------------------------------------------
// adc_axi_pkg
// Shared definitions for the ADC sample write arbiter:
//   - arbState_e      : arbiter state encoding (IDLE, SEND, RESP)
//   - RESP_*          : AXI write response encodings
//   - ERR_*           : sticky error codes reported on ERR_CODE
//   - errCodeOf()     : maps a write response (or a watchdog expiry) to an
//                       error code
// ---------------------------------------------------------------------------
package adc_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } arbState_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_DECERR  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Response 2'b10 is reported with code 2'b10; the two other non-OKAY
    // encodings fold onto code 2'b01. A watchdog expiry overrides the response.
    function automatic logic [1:0] errCodeOf(input logic [1:0] bresp, input logic timedOut);
        logic [1:0] code;
        code = ERR_NONE;
        if (timedOut) begin
            code = ERR_TIMEOUT;
        end else begin
            case (bresp)
                RESP_OKAY:                code = ERR_NONE;
                RESP_SLVERR:              code = ERR_DECERR;
                RESP_EXOKAY, RESP_DECERR: code = ERR_SLVERR;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/adc_axi_write_arbiter_rr.sv
// ---------------------------------------------------------------------------
// adc_rr_arbiter
// Purely combinational round-robin pick: the first set request found when
// searching upward from lastGrant_i+1, wrapping around.
// Ports:
//   req_i        in  NUM_REQ   request vector
//   lastGrant_i  in  log2      index granted most recently
//   enable_i     in  1         grants are only produced when high
//   grantValid_o out 1         a request was selected
//   grantIdx_o   out log2      selected index
// ---------------------------------------------------------------------------
module adc_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] lastGrant_i,
    input  logic                       enable_i,
    output logic                       grantValid_o,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Walk the candidates from the farthest to the nearest so the nearest
    // valid one (smallest distance past lastGrant_i) is written last and wins.
    always_comb begin
        int                cand;
        logic [IDX_W-1:0]  candIdx;
        cand         = 0;
        candIdx      = '0;
        grantValid_o = 1'b0;
        grantIdx_o   = '0;
        if (enable_i) begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                cand    = (int'(lastGrant_i) + k) % NUM_REQ;
                candIdx = cand[IDX_W-1:0];
                if (req_i[candIdx]) begin
                    grantValid_o = 1'b1;
                    grantIdx_o   = candIdx;
                end
            end
        end
    end

endmodule

// File: rtl/adc_axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// adc_axi_write_arbiter
// Shares one AXI4-Lite write master between NUM_REQ ADC sample sources. One
// 32-bit sample is accepted at a time (round-robin), written into the
// requester's ring-buffer region, and the write response is checked.
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET   clock, synchronous active-high reset
//   ENABLE                      permits new grants
//   REQ_VALID/REQ_DATA/REQ_READY per-requester sample input, one-hot accept
//   ERR_CLEAR/ERROR/ERR_CODE/ERR_SRC  sticky first-error report
//   BUSY                        high whenever not IDLE
//   M_AXI_AW*/W*/B*             AXI4-Lite write channels
// Build option: define ADC_ARB_BTIMEOUT_EN to add a B-response watchdog of
// TIMEOUT_CYCLES cycles that abandons the response and logs code 2'b11.
// ---------------------------------------------------------------------------
module adc_axi_write_arbiter
    import adc_axi_pkg::*;
#(
    parameter int          NUM_REQ                    = 4,
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
    parameter int          REGION_BYTES               = 1024,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          TIMEOUT_CYCLES             = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          ENABLE,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*32-1:0]         REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          ERR_CLEAR,
    output logic                          ERROR,
    output logic [1:0]                    ERR_CODE,
    output logic [2:0]                    ERR_SRC,
    output logic                          BUSY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    localparam int                IDX_W = $clog2(NUM_REQ);
    localparam int                OFF_W = $clog2(REGION_BYTES);
    localparam int                AW    = C_M_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0]     BASE  = AW'(C_M_TARGET_SLAVE_BASE_ADDR);

    if (NUM_REQ < 2 || NUM_REQ > 8 || REGION_BYTES < 8 ||
        (REGION_BYTES & (REGION_BYTES - 1)) != 0 ||
        C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("adc_axi_write_arbiter: unsupported parameter set");
    end

    arbState_e          state_q;
    logic [IDX_W-1:0]   lastGrant_q;
    logic [IDX_W-1:0]   grant_q;
    logic [OFF_W-1:0]   offset_q [NUM_REQ];
    logic [AW-1:0]      awaddr_q;
    logic [31:0]        wdata_q;
    logic               awvalid_q;
    logic               wvalid_q;
    logic               bready_q;
    logic [NUM_REQ-1:0] reqReady_q;
    logic               error_q;
    logic [1:0]         errCode_q;
    logic [2:0]         errSrc_q;

    logic               arbValid;
    logic [IDX_W-1:0]   arbIdx;
    logic [31:0]        reqWord [NUM_REQ];
    logic [AW-1:0]      grantAddr;
    logic               respDone;
    logic               timedOut;
    logic [1:0]         newCode;
    logic               newErr;

    adc_rr_arbiter #(.NUM_REQ(NUM_REQ)) uArbiter (
        .req_i        (REQ_VALID),
        .lastGrant_i  (lastGrant_q),
        .enable_i     (ENABLE && (state_q == ST_IDLE)),
        .grantValid_o (arbValid),
        .grantIdx_o   (arbIdx)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : gWords
        assign reqWord[i] = REQ_DATA[32*i +: 32];
    end

    assign grantAddr = BASE + (AW'(arbIdx) << OFF_W) + AW'(offset_q[arbIdx]);

`ifdef ADC_ARB_BTIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer_q;
`endif

    // The response phase ends either on BVALID or, when the watchdog is
    // built in, once the RESP state has lasted TIMEOUT_CYCLES cycles.
    always_comb begin
        respDone = 1'b0;
        timedOut = 1'b0;
        if (state_q == ST_RESP) begin
            if (M_AXI_BVALID) begin
                respDone = 1'b1;
            end
`ifdef ADC_ARB_BTIMEOUT_EN
            else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                respDone = 1'b1;
                timedOut = 1'b1;
            end
`endif
        end
    end

    assign newCode = respDone ? errCodeOf(M_AXI_BRESP, timedOut) : ERR_NONE;
    assign newErr  = (newCode != ERR_NONE);

    // Main sequencer: grant in IDLE, run AW/W independently in SEND, wait
    // for the response in RESP. A failed write leaves the offset alone so
    // the same slot is retried by the requester's next sample. The sticky
    // error only records the first failure, but an error arriving with
    // ERR_CLEAR replaces the old one instead of being lost.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= IDX_W'(NUM_REQ - 1);
            grant_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                offset_q[i] <= '0;
            end
            awaddr_q    <= BASE;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            reqReady_q  <= '0;
            error_q     <= 1'b0;
            errCode_q   <= ERR_NONE;
            errSrc_q    <= '0;
`ifdef ADC_ARB_BTIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            reqReady_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arbValid) begin
                        reqReady_q  <= NUM_REQ'(1) << arbIdx;
                        grant_q     <= arbIdx;
                        lastGrant_q <= arbIdx;
                        awaddr_q    <= grantAddr;
                        wdata_q     <= reqWord[arbIdx];
                        awvalid_q   <= 1'b1;
                        wvalid_q    <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_RESP;
`ifdef ADC_ARB_BTIMEOUT_EN
                        timer_q  <= '0;
`endif
                    end
                end
                ST_RESP: begin
                    if (respDone) begin
                        bready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (!newErr) begin
                            offset_q[grant_q] <= offset_q[grant_q] + OFF_W'(4);
                        end
                    end
`ifdef ADC_ARB_BTIMEOUT_EN
                    else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase

            if (newErr && (!error_q || ERR_CLEAR)) begin
                error_q   <= 1'b1;
                errCode_q <= newCode;
                errSrc_q  <= 3'(grant_q);
            end else if (ERR_CLEAR) begin
                error_q   <= 1'b0;
                errCode_q <= ERR_NONE;
                errSrc_q  <= '0;
            end
        end
    end

    assign REQ_READY     = reqReady_q;
    assign ERROR         = error_q;
    assign ERR_CODE      = errCode_q;
    assign ERR_SRC       = errSrc_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_adc_axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adc_axi_write_arbiter
// Directed bench for adc_axi_write_arbiter with a small AXI slave model and
// a scoreboard monitor that checks grants, AW addresses and W data.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_axi_write_arbiter;

    localparam int NUM_REQ = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enable;
    logic [NUM_REQ-1:0]     reqValid;
    logic [NUM_REQ*32-1:0]  reqData;
    logic [NUM_REQ-1:0]     reqReady;
    logic                   errClear;
    logic                   error;
    logic [1:0]             errCode;
    logic [2:0]             errSrc;
    logic                   busy;
    logic [31:0]            awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [31:0]            wdata;
    logic [3:0]             wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          expGrantQ [$];
    logic [31:0] expAddrQ  [$];
    logic [31:0] expDataQ  [$];

    int          awDelay   = 0;
    int          wDelay    = 0;
    logic        bNever    = 1'b0;
    logic [1:0]  brespNext = 2'b00;

    adc_axi_write_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .M_AXI_ACLK    (clock),
        .M_AXI_ARESET  (reset),
        .ENABLE        (enable),
        .REQ_VALID     (reqValid),
        .REQ_DATA      (reqData),
        .REQ_READY     (reqReady),
        .ERR_CLEAR     (errClear),
        .ERROR         (error),
        .ERR_CODE      (errCode),
        .ERR_SRC       (errSrc),
        .BUSY          (busy),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    always #5 clock = ~clock;

    // Free-running cycle count used for throughput spacing.
    initial begin
        forever begin
            @(posedge clock);
            cycle++;
        end
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pushExpect(input int idx, input logic [31:0] addr, input logic [31:0] data);
        expGrantQ.push_back(idx);
        expAddrQ.push_back(addr);
        expDataQ.push_back(data);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("idleWait", 32'(busy), 32'd0);
    endtask

    task automatic waitAccept(input int idx);
        int n = 0;
        while (reqReady[idx] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("acceptWait", 32'(reqReady[idx]), 32'd1);
    endtask

    // One full write from requester idx, finishing back in IDLE.
    task automatic applyStimulus(input int idx, input logic [31:0] data, input logic [31:0] addr, input logic [1:0] resp);
        pushExpect(idx, addr, data);
        brespNext = resp;
        reqData[idx*32 +: 32] = data;
        reqValid[idx] = 1'b1;
        waitAccept(idx);
        reqValid[idx] = 1'b0;
        waitIdle();
    endtask

    task automatic checkErr(input logic expErr, input logic [1:0] expCode, input logic [2:0] expSrc);
        checkOutput("error", 32'(error), 32'(expErr));
        checkOutput("errCode", 32'(errCode), 32'(expCode));
        checkOutput("errSrc", 32'(errSrc), 32'(expSrc));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstAwvalid", 32'(awvalid), 32'd0);
        checkOutput("rstWvalid", 32'(wvalid), 32'd0);
        checkOutput("rstBready", 32'(bready), 32'd0);
        checkOutput("rstReqReady", 32'(reqReady), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstAwaddr", awaddr, 32'h40000000);
        checkOutput("rstWdata", wdata, 32'd0);
        checkErr(1'b0, 2'b00, 3'd0);
    endtask

    // Slave model: AWREADY/WREADY rise after a programmable number of
    // cycles of VALID; BVALID answers BREADY unless suppressed.
    initial begin
        int awCnt = 0;
        int wCnt  = 0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            if (awvalid === 1'b1) begin
                awready = (awCnt >= awDelay);
                awCnt++;
            end else begin
                awready = 1'b0;
                awCnt   = 0;
            end
            if (wvalid === 1'b1) begin
                wready = (wCnt >= wDelay);
                wCnt++;
            end else begin
                wready = 1'b0;
                wCnt   = 0;
            end
            bvalid = (bready === 1'b1) && !bNever;
            bresp  = brespNext;
        end
    end

    // Scoreboard monitor: pops and compares whenever the DUT presents a
    // grant pulse or completes an AW or W handshake.
    initial begin
        int g;
        forever begin
            @(negedge clock);
            if (reqReady != '0) begin
                checkOutput("grantQueue", 32'(expGrantQ.size() > 0), 32'd1);
                if (expGrantQ.size() > 0) begin
                    g = expGrantQ.pop_front();
                    checkOutput("grant", 32'(reqReady), 32'(1 << g));
                end
            end
            if (awvalid && awready) begin
                checkOutput("awQueue", 32'(expAddrQ.size() > 0), 32'd1);
                if (expAddrQ.size() > 0) begin
                    checkOutput("awaddr", awaddr, expAddrQ.pop_front());
                    checkOutput("awprot", 32'(awprot), 32'd0);
                end
            end
            if (wvalid && wready) begin
                checkOutput("wQueue", 32'(expDataQ.size() > 0), 32'd1);
                if (expDataQ.size() > 0) begin
                    checkOutput("wdata", wdata, expDataQ.pop_front());
                    checkOutput("wstrb", 32'(wstrb), 32'hF);
                end
            end
        end
    end

    initial begin
        int cnt [NUM_REQ];
        int prev;
        int n;
        int awHi;
        int wHi;
        int brFirst;

        reset    = 1'b1;
        enable   = 1'b1;
        reqValid = '0;
        reqData  = '0;
        errClear = 1'b0;

        // Reset values
        repeat (3) tick();
        checkResetOutputs();
        reset = 1'b0;
        tick();

        // Requester 1 alone: offsets walk by 4 and wrap after 256 writes
        for (int k = 0; k < 258; k++) begin
            applyStimulus(1, 32'hA1000000 + 32'(k), 32'h40000400 + 32'((k % 256) * 4), 2'b00);
        end

        // Fresh reset, then all four requesters continuously valid
        reset = 1'b1;
        tick();
        checkResetOutputs();
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0;
            reqData[i*32 +: 32] = 32'hC0000000 + 32'(i << 24);
        end
        for (int k = 0; k < 8; k++) begin
            pushExpect(k % 4, 32'h40000000 + 32'((k % 4) * 1024 + 4 * (k / 4)),
                       32'hC0000000 + 32'((k % 4) << 24) + 32'(k / 4));
        end
        brespNext = 2'b00;
        reqValid  = '1;
        prev      = 0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (reqReady == '0 && n < 20) begin
                tick();
                n++;
            end
            checkOutput("rrAccept", 32'(reqReady != '0), 32'd1);
            if (k > 0) begin
                checkOutput("rrSpacing", 32'(cycle - prev), 32'd3);
            end
            prev = cycle;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reqReady[i]) begin
                    cnt[i]++;
                    reqData[i*32 +: 32] = 32'hC0000000 + 32'(i << 24) + 32'(cnt[i]);
                end
            end
            if (k == 7) begin
                reqValid = '0;
            end
            tick();
        end
        waitIdle();

        // ENABLE low holds off new grants
        enable = 1'b0;
        reqData[1*32 +: 32] = 32'hB1B1B1B1;
        reqValid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("disabledReady", 32'(reqReady), 32'd0);
            checkOutput("disabledBusy", 32'(busy), 32'd0);
        end
        enable = 1'b1;
        applyStimulus(1, 32'hB1B1B1B1, 32'h40000408, 2'b00);

        // AWREADY four cycles late, WREADY immediate
        awDelay = 4;
        pushExpect(0, 32'h40000008, 32'hD0D00004);
        reqData[0*32 +: 32] = 32'hD0D00004;
        reqValid[0] = 1'b1;
        waitAccept(0);
        reqValid[0] = 1'b0;
        awHi    = 0;
        wHi     = 0;
        brFirst = -1;
        for (int j = 0; j < 10; j++) begin
            if (awvalid) awHi++;
            if (wvalid) wHi++;
            if (bready && brFirst < 0) brFirst = j;
            tick();
        end
        checkOutput("awvalidCycles", 32'(awHi), 32'd5);
        checkOutput("wvalidCycles", 32'(wHi), 32'd1);
        checkOutput("breadyRise", 32'(brFirst), 32'd5);
        awDelay = 0;
        waitIdle();

        // Sticky first error, offsets held on failed writes, then clear
        applyStimulus(2, 32'hE2000000, 32'h40000808, 2'b10);
        checkErr(1'b1, 2'b10, 3'd2);
        applyStimulus(3, 32'hE3000000, 32'h40000C08, 2'b01);
        checkErr(1'b1, 2'b10, 3'd2);
        applyStimulus(2, 32'hE2000001, 32'h40000808, 2'b00);
        applyStimulus(3, 32'hE3000001, 32'h40000C08, 2'b00);
        checkErr(1'b1, 2'b10, 3'd2);
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        checkErr(1'b0, 2'b00, 3'd0);

`ifdef ADC_ARB_BTIMEOUT_EN
        // B response never arrives: give up after 16 RESP cycles
        bNever = 1'b1;
        pushExpect(1, 32'h4000040C, 32'hF1000000);
        reqData[1*32 +: 32] = 32'hF1000000;
        reqValid[1] = 1'b1;
        waitAccept(1);
        reqValid[1] = 1'b0;
        n = 0;
        while (!bready && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (bready && n < 100) begin
            tick();
            n++;
        end
        checkOutput("timeoutCycles", 32'(n), 32'd16);
        checkOutput("timeoutBusy", 32'(busy), 32'd0);
        checkErr(1'b1, 2'b11, 3'd1);
        bNever = 1'b0;
        errClear = 1'b1;
        tick();
        errClear = 1'b0;
        applyStimulus(1, 32'hF1000001, 32'h4000040C, 2'b00);
        checkErr(1'b0, 2'b00, 3'd0);
`endif

        // Reset in the middle of SEND
        awDelay = 10;
        wDelay  = 10;
        expGrantQ.push_back(2);
        reqData[2*32 +: 32] = 32'h99999999;
        reqValid[2] = 1'b1;
        waitAccept(2);
        reqValid[2] = 1'b0;
        checkOutput("sendBusy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        checkResetOutputs();
        reset   = 1'b0;
        awDelay = 0;
        wDelay  = 0;
        pushExpect(0, 32'h40000000, 32'hE0E00000);
        reqData[0*32 +: 32] = 32'hE0E00000;
        reqData[3*32 +: 32] = 32'hE3E30000;
        reqValid[0] = 1'b1;
        reqValid[3] = 1'b1;
        n = 0;
        while (reqReady == '0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("postResetGrant", 32'(reqReady), 32'd1);
        reqValid = '0;
        waitIdle();

        repeat (3) tick();
        checkOutput("grantQLeft", 32'(expGrantQ.size()), 32'd0);
        checkOutput("addrQLeft", 32'(expAddrQ.size()), 32'd0);
        checkOutput("dataQLeft", 32'(expDataQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_axi_write_arbiter.md
# adc_axi_write_arbiter

Shares one AXI4-Lite write master port between NUM_REQ ADC sample sources. Accepts one 32-bit sample at a time from the requesters using round-robin selection. Writes each sample to that requester's ring-buffer region in memory, then checks the write response. Sits between the ADC sample front-ends and the interconnect, in place of a single-source fixed-count write master.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h40000000, base of region 0
- REGION_BYTES, 1024, bytes per requester region; power of two, ≥8
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (fixed 32)
- TIMEOUT_CYCLES, 256, B-response watchdog limit (only used with the timeout macro)

Ports:
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESET  in  1  synchronous reset, active-high
- ENABLE  in  1  permits new grants
- REQ_VALID  in  NUM_REQ  per-requester sample valid
- REQ_DATA  in  NUM_REQ*32  per-requester sample; requester i uses bits [32i+31:32i]
- REQ_READY  out  NUM_REQ  one-hot accept pulse
- ERR_CLEAR  in  1  clears sticky error
- ERROR  out  1  sticky error flag
- ERR_CODE  out  2  00 none, 01 SLVERR, 10 DECERR, 11 timeout
- ERR_SRC  out  3  requester index of the first error
- BUSY  out  1  high whenever the state is not IDLE
- M_AXI_AWADDR  out  C_M_AXI_ADDR_WIDTH  write address
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
- M_AXI_WDATA  out  32  write data
- M_AXI_WSTRB  out  4  constant 4'hF
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  W handshake
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID / M_AXI_BREADY  in/out  1  B handshake

## Operation
- States: IDLE, SEND, RESP.
- IDLE:
  - If ENABLE and any REQ_VALID is set, grant the first valid index searching upward from last_grant+1, wrapping.
  - Pulse REQ_READY[g] for that one cycle.
  - Latch the data and AWADDR = BASE + g*REGION_BYTES + offset[g].
  - Set last_grant = g and go to SEND.
- SEND:
  - AWVALID and WVALID rise together.
  - Each drops independently on its own handshake; AW and W may complete in either order or in the same cycle.
  - When both have completed, go to RESP.
  - AWADDR and WDATA are held stable while their valid is high.
- RESP:
  - BREADY = 1. On BVALID, go to IDLE.
  - BRESP = 00: offset[g] += 4, wrapping to 0 at REGION_BYTES.
  - BRESP ≠ 00: offset[g] is unchanged (the slot is retried by the next sample).
  - Any non-OKAY BRESP (01 or 11 → code 01, 10 → code 10): if ERROR = 0, set ERROR and ERR_CODE, and set ERR_SRC = g. Later errors do not overwrite.
- ERR_CLEAR clears ERROR, ERR_CODE and ERR_SRC. If a new error arrives in the same cycle, the new error wins.
- Each requester has its own offset counter, log2(REGION_BYTES) bits wide.
- ENABLE low stops new grants only. A transaction already in flight completes normally.

## Timing
- Reset values:
  - State IDLE; all VALID, BREADY and REQ_READY outputs 0.
  - ERROR = 0, ERR_CODE = 0, ERR_SRC = 0, BUSY = 0.
  - AWADDR = BASE, WDATA = 0.
  - All offsets 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-transaction: every output returns to its reset value on the next edge.
- Accept at cycle t → AWVALID and WVALID high at t+1.
  - With AWREADY and WREADY high at t+1, BREADY is high at t+2.
  - With BVALID at t+2, the state is IDLE at t+3 and the next accept can occur at t+3.
  - Peak throughput is one write per 3 cycles.
- REQ_READY is registered and never depends combinationally on REQ_VALID.

## Configuration
- ADC_ARB_BTIMEOUT_EN defined:
  - A counter runs in RESP.
  - If BVALID has not arrived after TIMEOUT_CYCLES cycles, BREADY drops and the state goes to IDLE.
  - The error is logged with code 11 (subject to sticky-first) and offset[g] is unchanged.
- ADC_ARB_BTIMEOUT_EN undefined: RESP waits for BVALID indefinitely, and ERR_CODE never reports 11.

## Structure
- Package adc_axi_pkg holds:
  - the state enum;
  - AXI response constants OKAY, EXOKAY, SLVERR, DECERR;
  - ERR_CODE constants.
- Sub-module adc_rr_arbiter, parameterized by NUM_REQ:
  - inputs: request vector, last_grant, enable;
  - outputs: grant-valid and grant index, purely combinational;
  - the top level registers its outputs.

## Test plan
- Single requester 1 repeatedly, slave always ready with BRESP 00 → AWADDR sequence 0x40000400, 0x40000404, …; after 256 writes it wraps back to 0x40000400.
- All 4 requesters continuously valid → grants in order 0,1,2,3,0; exactly one REQ_READY pulse every 3 cycles.
- AWREADY delayed 4 cycles while WREADY is immediate → WVALID drops after 1 cycle and AWVALID holds for 5; BREADY rises only after both handshakes complete.
- BRESP = 10 on requester 2, then BRESP = 01 on requester 3 → ERROR = 1, ERR_CODE = 10, ERR_SRC = 2; offsets[2] and [3] unchanged. ERR_CLEAR → all cleared.
- With ADC_ARB_BTIMEOUT_EN and TIMEOUT_CYCLES = 16, BVALID never asserted → state returns to IDLE after 16 cycles in RESP, with ERR_CODE = 11.
- M_AXI_ARESET asserted during SEND → AWVALID, WVALID and BUSY are 0 the next cycle; the next grant goes to requester 0 at offset 0.
